ramp_step_gen: RTL and testbench



---
 rtl/ramp_step_pkg.sv | 16 +
 rtl/ramp_step_gen_sat_add32.sv | 25 ++
 rtl/ramp_step_gen.sv | 123 ++++++++++++
 tb/tb_ramp_step_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ramp_step_pkg.sv
// Shared types and constants for the FOG ramp/step feedback loop.
package ramp_step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCALE = 3'd1,
    ST_ACCUM = 3'd2,
    ST_RAMP  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam logic [31:0] STEP_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] STEP_MIN = 32'h8000_0000;
  localparam int          GAIN_W   = 5;

endpackage

// File: rtl/ramp_step_gen_sat_add32.sv
// Signed 32 + 32 adder clipped to the 32-bit signed range, with a clip flag.
module sat_add32
  import ramp_step_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum,
  output logic        o_sat
);

  logic [32:0] w_wide;

  // 33-bit sum; disagreement of the top two bits means the result left the range
  always_comb begin
    w_wide = {i_a[31], i_a} + {i_b[31], i_b};
    if (w_wide[32] != w_wide[31]) begin
      o_sat = 1'b1;
      o_sum = w_wide[32] ? STEP_MIN : STEP_MAX;
    end else begin
      o_sat = 1'b0;
      o_sum = w_wide[31:0];
    end
  end

endmodule

// File: rtl/ramp_step_gen.sv
// Closed-loop rate stage: scales each error sample, integrates it into a
// saturating step register and accumulates the step into a wrapping phase ramp.
module ramp_step_gen
  import ramp_step_pkg::*;
#(
  parameter int DAC_BIT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_sync,
  input  logic [31:0]        i_err,
  input  logic [GAIN_W-1:0]  i_gain_sel,
  input  logic               i_loop_en,
  input  logic [31:0]        i_step_init,
  output logic [31:0]        o_step,
  output logic [31:0]        o_ramp,
  output logic [DAC_BIT-1:0] o_dac,
  output logic               o_valid,
  output logic               o_step_sat,
  output logic               o_overrun
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GAIN_W-1:0] r_gain_sel;
  logic              r_sync_d;
  logic [31:0]       r_err;
  logic [31:0]       r_scaled;
  logic [31:0]       r_step;
  logic [31:0]       r_ramp;
  logic              r_valid;
  logic              r_step_sat;
  logic              r_overrun;

  logic              w_sync_edge;
  logic              w_ready;
  logic              w_accept;
  logic              w_drop;
  logic [31:0]       w_sum;
  logic              w_sat;

  assign w_sync_edge = i_sync & ~r_sync_d;
  // OUT is the last cycle of a sample, so a new edge there keeps the 4-clock rate
  assign w_ready     = (r_state == ST_IDLE) || (r_state == ST_OUT);
  assign w_accept    = i_loop_en & w_sync_edge & w_ready;
  assign w_drop      = i_loop_en & w_sync_edge & ~w_ready;

  sat_add32 u_sat_add (
    .i_a   (r_step),
    .i_b   (r_scaled),
    .o_sum (w_sum),
    .o_sat (w_sat)
  );

  // Next-state: loop disable forces IDLE from any state
  always_comb begin
    w_state_nxt = r_state;
    if (!i_loop_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = w_accept ? ST_SCALE : ST_IDLE;
        ST_SCALE: w_state_nxt = ST_ACCUM;
        ST_ACCUM: w_state_nxt = ST_RAMP;
        ST_RAMP:  w_state_nxt = ST_OUT;
        ST_OUT:   w_state_nxt = w_accept ? ST_SCALE : ST_IDLE;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State, input capture and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_gain_sel <= {GAIN_W{1'b0}};
      r_sync_d   <= 1'b0;
      r_err      <= 32'd0;
      r_scaled   <= 32'd0;
      r_step     <= 32'd0;
      r_ramp     <= 32'd0;
      r_valid    <= 1'b0;
      r_step_sat <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gain_sel <= i_gain_sel;
      r_sync_d   <= i_sync;
      if (!i_loop_en) begin
        r_step     <= i_step_init;
        r_ramp     <= 32'd0;
        r_valid    <= 1'b0;
        r_step_sat <= 1'b0;
        r_overrun  <= 1'b0;
      end else begin
        r_valid <= (r_state == ST_RAMP);
        if (w_accept) begin
          r_err <= i_err;
        end
        if (w_drop) begin
          r_overrun <= 1'b1;
        end
        case (r_state)
          ST_SCALE: r_scaled <= $signed(r_err) >>> r_gain_sel;
          ST_ACCUM: begin
            r_step     <= w_sum;
            r_step_sat <= w_sat;
          end
          ST_RAMP:  r_ramp <= r_ramp + r_step;
          default:  r_scaled <= r_scaled;
        endcase
      end
    end
  end

  assign o_step     = r_step;
  assign o_ramp     = r_ramp;
  assign o_dac      = {~r_ramp[31], r_ramp[30:32-DAC_BIT]};
  assign o_valid    = r_valid;
  assign o_step_sat = r_step_sat;
  assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_ramp_step_gen.sv
// Directed bench for ramp_step_gen with hand-computed expectations.
module tb_ramp_step_gen;

  logic        clk;
  logic        rst_n;
  logic        sync;
  logic [31:0] err;
  logic [4:0]  gain_sel;
  logic        loop_en;
  logic [31:0] step_init;
  logic [31:0] step;
  logic [31:0] ramp;
  logic [15:0] dac;
  logic        valid;
  logic        step_sat;
  logic        overrun;

  int n_total = 0;
  int n_bad   = 0;

  ramp_step_gen #(.DAC_BIT(16)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_sync      (sync),
    .i_err       (err),
    .i_gain_sel  (gain_sel),
    .i_loop_en   (loop_en),
    .i_step_init (step_init),
    .o_step      (step),
    .o_ramp      (ramp),
    .o_dac       (dac),
    .o_valid     (valid),
    .o_step_sat  (step_sat),
    .o_overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp_v);
    end
  endtask

  // Hold loop_en low across one clock so the preset is loaded.
  task automatic preset(input logic [31:0] init);
    @(negedge clk);
    step_init = init;
    loop_en   = 1'b0;
    @(negedge clk);
    loop_en   = 1'b1;
  endtask

  // One sync pulse, checking outputs at k+2, k+3 and k+4.
  task automatic send(input string tag, input logic [31:0] e, input logic [31:0] x_step,
                      input logic [31:0] x_ramp, input logic [31:0] x_dac, input logic x_sat);
    @(negedge clk);
    err  = e;
    sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".step"}, step, x_step);
    chk({tag, ".valid_k2"}, {31'd0, valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_k3"}, {31'd0, valid}, 32'd1);
    chk({tag, ".ramp"}, ramp, x_ramp);
    chk({tag, ".dac"}, {16'd0, dac}, x_dac);
    chk({tag, ".sat"}, {31'd0, step_sat}, {31'd0, x_sat});
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".valid_k4"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int pulses;
    rst_n     = 1'b0;
    sync      = 1'b0;
    err       = 32'd0;
    gain_sel  = 5'd0;
    loop_en   = 1'b0;
    step_init = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.step", step, 32'd0);
    chk("rst.ramp", ramp, 32'd0);
    chk("rst.dac", {16'd0, dac}, 32'h0000_8000);
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    preset(32'd0);

    send("basic1", 32'd100, 32'd100, 32'd100, 32'h8000, 1'b0);
    send("basic2", -32'sd30, 32'd70, 32'd170, 32'h8000, 1'b0);

    gain_sel = 5'd4;
    preset(32'd0);
    send("shift1", -32'sd17, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'h7FFF, 1'b0);
    send("shift2", 32'd15, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h7FFF, 1'b0);

    gain_sel = 5'd0;
    preset(32'h7FFF_FFF0);
    send("satp", 32'h100, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF, 1'b1);
    send("satp2", 32'hFFFF_FFFF, 32'h7FFF_FFFE, 32'hFFFF_FFFD, 32'h7FFF, 1'b0);
    preset(32'h8000_0010);
    send("satn", 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h0000, 1'b1);

    preset(32'h4000_0000);
    send("wrap1", 32'd0, 32'h4000_0000, 32'h4000_0000, 32'hC000, 1'b0);
    send("wrap2", 32'd0, 32'h4000_0000, 32'h8000_0000, 32'h0000, 1'b0);
    send("wrap3", 32'd0, 32'h4000_0000, 32'hC000_0000, 32'h4000, 1'b0);
    send("wrap4", 32'd0, 32'h4000_0000, 32'h0000_0000, 32'h8000, 1'b0);

    // Overrun: second edge sampled two clocks after the first
    preset(32'd0);
    chk("ovr.clear0", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    err  = 32'd5;
    sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b1;
    err  = 32'd9;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0;
    chk("ovr.step", step, 32'd5);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("ovr.pulses", pulses, 32'd1);
    chk("ovr.flag", {31'd0, overrun}, 32'd1);
    chk("ovr.ramp", ramp, 32'd5);
    preset(32'd0);
    chk("ovr.cleared", {31'd0, overrun}, 32'd0);

    // Abort: loop_en dropped the cycle after the sync edge
    preset(32'h0000_1234);
    @(negedge clk);
    err  = 32'd50;
    sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync    = 1'b0;
    loop_en = 1'b0;
    pulses  = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("abort.pulses", pulses, 32'd0);
    chk("abort.step", step, 32'h0000_1234);
    chk("abort.ramp", ramp, 32'd0);
    loop_en = 1'b1;

    // Async reset while the FSM sits in ACCUM
    send("pre_rst", 32'd7, 32'h0000_123B, 32'h0000_123B, 32'h8000, 1'b0);
    @(negedge clk);
    err  = 32'h7FFF_0000;
    sync = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sync = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst.step", step, 32'd0);
    chk("arst.ramp", ramp, 32'd0);
    chk("arst.dac", {16'd0, dac}, 32'h0000_8000);
    chk("arst.valid", {31'd0, valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) pulses++;
    end
    chk("arst.nopulse", pulses, 32'd0);
    chk("arst.step2", step, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
